axis_bin2x2: RTL



---
 rtl/axis_bin2x2_pkg.sv | 7 +
 rtl/axis_bin2x2_linebuf.sv | 20 ++
 rtl/axis_bin2x2.sv | 81 ++++++++
 3 files changed

// File: rtl/axis_bin2x2_pkg.sv
// axis_bin2x2_pkg: shared defaults and sum type for the 2x2 binning stage
package axis_bin2x2_pkg;
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGTH = 480;
    localparam int DEF_DATA_W = 8;
    typedef logic [DEF_DATA_W:0] psum_t;
endpackage

// File: rtl/axis_bin2x2_linebuf.sv
// axis_bin2x2_linebuf: even-row pair-sum store, synchronous write, combinational read
module axis_bin2x2_linebuf
    import axis_bin2x2_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH / 2,
    parameter int DW    = $bits(psum_t),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/axis_bin2x2.sv
// axis_bin2x2: 2x2 rounded-mean binning of an AXI4-Stream video frame
module axis_bin2x2
    import axis_bin2x2_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGTH = DEF_HEIGTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              m_aclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              line_err,
    output logic              frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGTH);
    logic [CW-1:0]     col, c;
    logic [RW-1:0]     row, r;
    logic              synced, take, eol, last_bin_row;
    logic [DATA_W-1:0] pair_lo;
    logic [DATA_W:0]   psum, lb_rd;
    logic [DATA_W+1:0] tot;
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign take = s_axis_tvalid && s_axis_tready && (synced || s_axis_tuser);
    // a tuser beat is always position (0,0), whatever the counters say
    assign c    = s_axis_tuser ? '0 : col;
    assign r    = s_axis_tuser ? '0 : row;
    assign eol  = (c == CW'(WIDTH - 1)) || s_axis_tlast;
    assign psum = {1'b0, pair_lo} + {1'b0, s_axis_tdata};
    assign tot  = (DATA_W+2)'(lb_rd) + (DATA_W+2)'(psum) + (DATA_W+2)'(2);
    axis_bin2x2_linebuf #(.DEPTH(WIDTH / 2), .DW(DATA_W + 1)) u_linebuf (
        .clk   (m_aclk),
        .we    (take && !r[0] && c[0]),
        .waddr (c[CW-1:1]),
        .wdata (psum),
        .raddr (c[CW-1:1]),
        .rdata (lb_rd)
    );
    always_ff @(posedge m_aclk) begin
        if (reset) begin
            col           <= '0;
            row           <= '0;
            synced        <= 1'b0;
            pair_lo       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            last_bin_row  <= 1'b0;
            line_err      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            line_err   <= take && (s_axis_tlast != (c == CW'(WIDTH - 1)));
            frame_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast && last_bin_row;
            if (take) begin
                synced <= 1'b1;
                col    <= eol ? '0 : c + 1'b1;
                row    <= !eol ? r : (r == RW'(HEIGTH - 1)) ? '0 : r + 1'b1;
                if (!c[0]) pair_lo <= s_axis_tdata;
            end
            if (take && r[0] && c[0]) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= tot[DATA_W+1:2];
                m_axis_tuser  <= r == RW'(1) && c == CW'(1);
                m_axis_tlast  <= c == CW'(WIDTH - 1);
                last_bin_row  <= r == RW'(HEIGTH - 1);
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule
